opn_timer_regs: RTL

- Register-side companion of the FM clock divider.
- Decodes CPU writes to the prescaler registers (0x2D/0x2E/0x2F) into the 2-bit `div_setting` that drives the divider.
- Consumes the divider's `clk_en` to run OPN Timer A (10-bit) and Timer B (8-bit, extra /16), with overflow flags, IRQ and a CSM overflow pulse.
- Sits between the CPU bus front-end and the divider/FM core.

---
 rtl/opn_timer_pkg.sv | 33 +++
 rtl/opn_timer_cnt.sv | 84 ++++++++
 rtl/opn_timer_regs.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/opn_timer_pkg.sv
// Shared constants for the OPN timer register block: register map, 0x27 bit
// positions and div_setting encodings.
package opn_timer_pkg;

   localparam logic [7:0] REG_TA_HI = 8'h24;
   localparam logic [7:0] REG_TA_LO = 8'h25;
   localparam logic [7:0] REG_TB    = 8'h26;
   localparam logic [7:0] REG_TCTL  = 8'h27;
   localparam logic [7:0] REG_PRES0 = 8'h2D;
   localparam logic [7:0] REG_PRES1 = 8'h2E;
   localparam logic [7:0] REG_PRES2 = 8'h2F;

   localparam int CTL_LOAD_A = 0;
   localparam int CTL_LOAD_B = 1;
   localparam int CTL_EN_A   = 2;
   localparam int CTL_EN_B   = 3;
   localparam int CTL_RST_A  = 4;
   localparam int CTL_RST_B  = 5;
   localparam int CTL_CSM_LO = 6;

   localparam logic [1:0] DIV_FM6 = 2'b10;
   localparam logic [1:0] DIV_FM3 = 2'b11;
   localparam logic [1:0] DIV_FM2 = 2'b00;

   // Stored part of register 0x27; the RST bits are strobes and never held.
   typedef struct packed {
      logic en_b;
      logic en_a;
      logic load_b;
      logic load_a;
   } tctl_t;

endpackage

// File: rtl/opn_timer_cnt.sv
// One OPN timer: optional power-of-two tick prescaler, up-counter with reload
// at all-ones, overflow pulse and sticky flag.
module opn_timer_cnt #(
   parameter int WIDTH = 10,
   parameter int PRES  = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clk_en_i,
   input  logic             bypass_i,
   input  logic             run_i,
   input  logic             load_i,
   input  logic             en_i,
   input  logic             clr_i,
   input  logic [WIDTH-1:0] val_i,
   output logic [WIDTH-1:0] cnt_o,
   output logic             flag_o,
   output logic             ovf_o
);

   logic             step;
   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic             flag_q, flag_d;
   logic             ovf_q, ovf_d;

   generate
      if (PRES > 1) begin : g_pres
         localparam int PW = $clog2(PRES);
         logic [PW-1:0] pres_q, pres_d;

         // Free-running while the timer runs; a reload never realigns it.
         always_comb begin
            pres_d = pres_q;
            if (run_i && clk_en_i) pres_d = pres_q + PW'(1);
         end

         always_ff @(posedge clk) begin
            if (rst) pres_q <= '0;
            else     pres_q <= pres_d;
         end

         assign step = bypass_i | (clk_en_i & (pres_q == PW'(PRES - 1)));
      end else begin : g_nopres
         assign step = bypass_i | clk_en_i;
      end
   endgenerate

   always_comb begin
      // NOTE: every output of this block gets a default first so no latch is inferred.
      cnt_d  = cnt_q;
      ovf_d  = 1'b0;
      flag_d = flag_q;
      if (load_i) begin
         cnt_d = val_i;
      end else if (run_i && step) begin
         if (&cnt_q) begin
            cnt_d = val_i;
            ovf_d = 1'b1;
         end else begin
            cnt_d = cnt_q + WIDTH'(1);
         end
      end
      if (clr_i)          flag_d = 1'b0;
      if (ovf_d && en_i)  flag_d = 1'b1;
   end

   // NOTE: state registers use non-blocking assignments so all update together at the edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q  <= '0;
         flag_q <= 1'b0;
         ovf_q  <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         flag_q <= flag_d;
         ovf_q  <= ovf_d;
      end
   end

   assign cnt_o  = cnt_q;
   assign flag_o = flag_q;
   assign ovf_o  = ovf_q;

endmodule

// File: rtl/opn_timer_regs.sv
// OPN timer register block: bus decode, FM prescaler select, Timer A/B.
// Define OPN_TIMER_READBACK_EN to add counter readback ports and fast_tick.
module opn_timer_regs
   import opn_timer_pkg::*;
#(
   parameter int         TB_PRES = 16,
   parameter logic [1:0] DIV_RST = 2'b10
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       clk_en,
   input  logic       wr,
   input  logic [7:0] addr,
   input  logic [7:0] din,
`ifdef OPN_TIMER_READBACK_EN
   input  logic       fast_tick,
   output logic [9:0] cnt_a_dbg,
   output logic [7:0] cnt_b_dbg,
`endif
   output logic [1:0] div_setting,
   output logic       flag_a,
   output logic       flag_b,
   output logic       irq_n,
   output logic       overflow_a,
   output logic [1:0] csm
);

   logic [1:0] div_q, div_d;
   logic [9:0] ta_q, ta_d;
   logic [7:0] tb_q, tb_d;
   tctl_t      tctl_q, tctl_d;
   logic [1:0] csm_q, csm_d;

   logic       wr_tctl;
   logic       start_a, start_b;
   logic       clr_a, clr_b;
   logic       bypass;
   logic [9:0] cnt_a;
   logic [7:0] cnt_b;
   logic       ovf_b_unused;

   always_comb begin
      div_d  = div_q;
      ta_d   = ta_q;
      tb_d   = tb_q;
      tctl_d = tctl_q;
      csm_d  = csm_q;
      if (wr) begin
         case (addr)
            REG_PRES0: div_d = DIV_FM6;
            REG_PRES1: if (div_q[1]) div_d = DIV_FM3;
            REG_PRES2: div_d = DIV_FM2;
            REG_TA_HI: ta_d[9:2] = din;
            REG_TA_LO: ta_d[1:0] = din[1:0];
            REG_TB:    tb_d = din;
            REG_TCTL: begin
               tctl_d.load_a = din[CTL_LOAD_A];
               tctl_d.load_b = din[CTL_LOAD_B];
               tctl_d.en_a   = din[CTL_EN_A];
               tctl_d.en_b   = din[CTL_EN_B];
               csm_d         = din[CTL_CSM_LO +: 2];
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         div_q  <= DIV_RST;
         ta_q   <= '0;
         tb_q   <= '0;
         tctl_q <= '0;
         csm_q  <= '0;
      end else begin
         div_q  <= div_d;
         ta_q   <= ta_d;
         tb_q   <= tb_d;
         tctl_q <= tctl_d;
         csm_q  <= csm_d;
      end
   end

   // Reload only on a rising LOAD bit; rewriting 1 leaves a running timer alone.
   assign wr_tctl = wr && (addr == REG_TCTL);
   assign start_a = wr_tctl && din[CTL_LOAD_A] && !tctl_q.load_a;
   assign start_b = wr_tctl && din[CTL_LOAD_B] && !tctl_q.load_b;
   assign clr_a   = wr_tctl && din[CTL_RST_A];
   assign clr_b   = wr_tctl && din[CTL_RST_B];

`ifdef OPN_TIMER_READBACK_EN
   logic [9:0] cnt_a_dbg_q;
   logic [7:0] cnt_b_dbg_q;

   assign bypass = fast_tick;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_a_dbg_q <= '0;
         cnt_b_dbg_q <= '0;
      end else begin
         cnt_a_dbg_q <= cnt_a;
         cnt_b_dbg_q <= cnt_b;
      end
   end

   assign cnt_a_dbg = cnt_a_dbg_q;
   assign cnt_b_dbg = cnt_b_dbg_q;
`else
   logic unused_cnt;

   assign bypass     = 1'b0;
   assign unused_cnt = ^{cnt_a, cnt_b, ovf_b_unused};
`endif

   opn_timer_cnt #(.WIDTH(10), .PRES(1)) u_tmr_a (
      .clk      (clk),
      .rst      (rst),
      .clk_en_i (clk_en),
      .bypass_i (bypass),
      .run_i    (tctl_q.load_a),
      .load_i   (start_a),
      .en_i     (tctl_q.en_a),
      .clr_i    (clr_a),
      .val_i    (ta_q),
      .cnt_o    (cnt_a),
      .flag_o   (flag_a),
      .ovf_o    (overflow_a)
   );

   opn_timer_cnt #(.WIDTH(8), .PRES(TB_PRES)) u_tmr_b (
      .clk      (clk),
      .rst      (rst),
      .clk_en_i (clk_en),
      .bypass_i (bypass),
      .run_i    (tctl_q.load_b),
      .load_i   (start_b),
      .en_i     (tctl_q.en_b),
      .clr_i    (clr_b),
      .val_i    (tb_q),
      .cnt_o    (cnt_b),
      .flag_o   (flag_b),
      .ovf_o    (ovf_b_unused)
   );

   assign div_setting = div_q;
   assign irq_n       = ~(flag_a | flag_b);
   assign csm         = csm_q;

endmodule
